// File: rtl/dm_byte_banks.sv
// Data-memory responder: four byte-wide banks addressed by byte address bits [1:0],
// byte/half/word accesses with per-byte bank rotation and a valid/ready response.
module dm_byte_banks #(
  parameter int unsigned BANK_AW = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned BYTE_AW = BANK_AW + 2;
  localparam int unsigned ROWS    = 1 << BANK_AW;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        cap_we;
  logic [1:0]  cap_width;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [7:0]  mem [4][ROWS];

  logic [2:0]         cnt_c;
  logic               err_c;
  logic [31:0]        rdata_c;
  logic [3:0]         wen_c;
  logic [BYTE_AW-1:0] b_c     [4];
  logic [BANK_AW-1:0] row_c   [4];
  logic [7:0]         wbyte_c [4];

  // Decode the captured request into per-byte bank/row lanes; byte k lands in bank (addr+k)[1:0]
  always_comb begin
    cnt_c   = 3'd0;
    rdata_c = '0;
    wen_c   = '0;
    for (int j = 0; j < 4; j++) begin
      b_c[j]     = '0;
      row_c[j]   = '0;
      wbyte_c[j] = '0;
    end
    case (cap_width)
      2'b00:   cnt_c = 3'd1;
      2'b01:   cnt_c = 3'd2;
      2'b10:   cnt_c = 3'd4;
      default: cnt_c = 3'd0;
    endcase
    err_c = (cap_width == 2'b11) || ((cap_addr >> BYTE_AW) != 32'd0);
    for (int k = 0; k < 4; k++) begin
      b_c[k] = cap_addr[BYTE_AW-1:0] + BYTE_AW'(k);
      if (3'(k) < cnt_c) begin
        rdata_c[8*k +: 8]     = mem[b_c[k][1:0]][b_c[k][BYTE_AW-1:2]];
        wen_c[b_c[k][1:0]]    = cap_we && !err_c && (state == ACCESS) && !rst;
        row_c[b_c[k][1:0]]    = b_c[k][BYTE_AW-1:2];
        wbyte_c[b_c[k][1:0]]  = cap_wdata[8*k +: 8];
      end
    end
  end

  // Bank storage writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (wen_c[j]) mem[j][row_c[j]] <= wbyte_c[j];
    end
  end

  // Request/response sequencing with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_we     <= 1'b0;
      cap_width  <= 2'b00;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cap_we    <= req_we;
            cap_width <= req_width;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            req_ready <= 1'b0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= err_c;
          resp_rdata <= (!cap_we && !err_c) ? rdata_c : 32'd0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_byte_banks.sv
// Self-checking bench for dm_byte_banks: directed vector table, corner sequences, random vs model.
module tb_dm_byte_banks;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int passed = 0;

  logic [7:0] mref [256];

  typedef struct {
    logic        we;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t tv[$];

  dm_byte_banks #(.BANK_AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_width  (req_width),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [1:0] w, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] rd, input logic er);
    vec_t v;
    v.we = we; v.w = w; v.a = a; v.d = d; v.rd = rd; v.er = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else passed++;
  endtask

  // Reference: memory is a flat 256-byte array; byte k of an access sits at (addr+k) mod 256
  task automatic model_req(input logic we, input logic [1:0] w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic er);
    int n;
    n  = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    er = (w == 2'd3) || (a >= 32'd256);
    rd = 32'd0;
    if (!er) begin
      for (int k = 0; k < n; k++) begin
        if (we) mref[(a + k) % 256] = d[8*k +: 8];
        else    rd[8*k +: 8] = mref[(a + k) % 256];
      end
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    req_we = we; req_width = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_width = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = resp_rdata; er = resp_err;
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd, erd, old10;
    logic        er, eer;
    int          lat;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_width = 2'd0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready",  32'(req_ready),  32'd1);
    chk("reset_resp_valid", 32'(resp_valid), 32'd0);
    chk("reset_resp_rdata", resp_rdata,      32'd0);
    chk("reset_resp_err",   32'(resp_err),   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known starting contents
    for (int i = 0; i < 64; i++) begin
      do_req(1'b1, 2'd2, 32'(4 * i), 32'd0, 0, rd, er, lat);
      model_req(1'b1, 2'd2, 32'(4 * i), 32'd0, erd, eer);
    end

    tv.push_back(mk(1, 2'd2, 32'h00, 32'hDEADBEEF, 32'h0, 0));
    tv.push_back(mk(0, 2'd2, 32'h00, 32'h0, 32'hDEADBEEF, 0));
    tv.push_back(mk(0, 2'd0, 32'h01, 32'h0, 32'h000000BE, 0));
    tv.push_back(mk(0, 2'd1, 32'h02, 32'h0, 32'h0000DEAD, 0));
    tv.push_back(mk(1, 2'd0, 32'h04, 32'h0, 32'h0, 0));
    tv.push_back(mk(1, 2'd2, 32'h05, 32'h44332211, 32'h0, 0));
    tv.push_back(mk(0, 2'd2, 32'h04, 32'h0, 32'h33221100, 0));
    tv.push_back(mk(0, 2'd2, 32'h08, 32'h0, 32'h00000044, 0));
    tv.push_back(mk(1, 2'd2, 32'hFE, 32'hA1B2C3D4, 32'h0, 0));
    tv.push_back(mk(0, 2'd0, 32'hFE, 32'h0, 32'h000000D4, 0));
    tv.push_back(mk(0, 2'd0, 32'hFF, 32'h0, 32'h000000C3, 0));
    tv.push_back(mk(0, 2'd0, 32'h00, 32'h0, 32'h000000B2, 0));
    tv.push_back(mk(0, 2'd0, 32'h01, 32'h0, 32'h000000A1, 0));
    tv.push_back(mk(0, 2'd3, 32'h00, 32'h0, 32'h0, 1));
    tv.push_back(mk(1, 2'd2, 32'h100, 32'h11111111, 32'h0, 1));
    tv.push_back(mk(0, 2'd2, 32'h00, 32'h0, 32'hDEADA1B2, 0));
    tv.push_back(mk(0, 2'd1, 32'hFF, 32'h0, 32'h0000B2C3, 0));
    tv.push_back(mk(1, 2'd0, 32'h03, 32'h12345677, 32'h0, 0));
    tv.push_back(mk(1, 2'd1, 32'h01, 32'h0000CCBB, 32'h0, 0));
    tv.push_back(mk(1, 2'd3, 32'h00, 32'hFFFFFFFF, 32'h0, 1));
    tv.push_back(mk(0, 2'd2, 32'h00, 32'h0, 32'h77CCBBB2, 0));
    tv.push_back(mk(0, 2'd0, 32'h80000000, 32'h0, 32'h0, 1));

    foreach (tv[i]) begin
      do_req(tv[i].we, tv[i].w, tv[i].a, tv[i].d, 0, rd, er, lat);
      model_req(tv[i].we, tv[i].w, tv[i].a, tv[i].d, erd, eer);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].er));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
    end

    // Backpressure: response held stable, no new request accepted
    model_req(1'b0, 2'd2, 32'h04, 32'h0, erd, eer);
    while (!req_ready) begin @(posedge clk); #1; end
    req_we = 1'b0; req_width = 2'd2; req_addr = 32'h04; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_addr = 32'($urandom);
      @(posedge clk); #1;
      chk($sformatf("hold%0d_valid", c), 32'(resp_valid), 32'd1);
      chk($sformatf("hold%0d_rdata", c), resp_rdata, erd);
      chk($sformatf("hold%0d_err", c), 32'(resp_err), 32'(eer));
      chk($sformatf("hold%0d_req_ready", c), 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;

    // Reset while the response is pending drops it
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_req_ready", 32'(req_ready), 32'd1);

    // Reset during ACCESS suppresses the store
    model_req(1'b0, 2'd2, 32'h10, 32'h0, old10, eer);
    req_we = 1'b1; req_width = 2'd2; req_addr = 32'h10; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_access_req_ready", 32'(req_ready), 32'd1);
    chk("rst_access_resp_valid", 32'(resp_valid), 32'd0);
    do_req(1'b0, 2'd2, 32'h10, 32'h0, 0, rd, er, lat);
    chk("rst_access_old_data", rd, old10);

    // Randomized traffic against the flat-memory model
    for (int i = 0; i < 150; i++) begin
      logic        we;
      logic [1:0]  w;
      logic [31:0] a, d;
      we = 1'($urandom);
      w  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      d  = $urandom;
      do_req(we, w, a, d, $urandom_range(0, 2), rd, er, lat);
      model_req(we, w, a, d, erd, eer);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_err", i), 32'(er), 32'(eer));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
